fpu_issue_queue: RTL and testbench
==================================

Name: fpu_issue_queue

Overview:
- In-order FPU issue queue. It sits between the dispatch stage and the FPU interconnect, and is the sender end of the en/reject message channel that carries FpuInstr to the FPU.
- It buffers up to DEPTH FPU instructions and snoops the writeback bus to capture pending source operands.
- The head entry is offered to the FPU interconnect once both of its operands are ready.
- flash discards all queued instructions.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
PHYS_W, 6, physical register tag width
CID_W, 4, commit_id width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
flash  in  1  pipeline flush; synchronous, same effect as reset
in_en  in  1  dispatch offers an instruction
in_msg  in  FpuInstr  funct5, dest_phys, dest_logic, commit_id, src1/src2 {ready, tag[PHYS_W], data[32]}
in_reject  out  1  queue cannot accept this cycle
wb_en  in  1  writeback broadcast valid
wb_phys  in  PHYS_W  writeback destination tag
wb_data  in  32  writeback value
out_en  out  1  head instruction offered to the FPU interconnect
out_msg  out  FpuInstr  head instruction with both sources ready and data filled
out_reject  in  1  FPU interconnect refuses the transfer this cycle

Behaviour:
- Handshake, both channels: a transfer occurs in a cycle where en=1 and reject=0. While out_en=1 and out_reject=1, out_msg is held bit-stable.
- Storage: circular buffer of DEPTH entries with head and tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Reset or flash (registered at the clock edge): count=0, head=tail=0, all entry valid bits cleared.
- Values during the cycle reset or flash is asserted: in_reject=1 and out_en=0. No transfer on either channel counts.
- Enqueue:
  - in_reject = (count==DEPTH). Full blocks enqueue even when a dequeue happens in the same cycle; there is no full-pass-through.
  - On accept, in_msg is written at tail, then tail+1.
  - If wb_en=1 and wb_phys equals the tag of a not-ready source of in_msg in that cycle, the stored source is written ready with data=wb_data. This prevents a missed wakeup.
- Wakeup: every cycle wb_en=1, each valid entry whose source i is not ready and has tag==wb_phys sets ready_i=1 and data_i=wb_data. Both sources of one entry may wake on the same broadcast.
- Issue:
  - out_en = (count!=0) & head.src1.ready & head.src2.ready, using registered flags only.
  - A wakeup at cycle t gives out_en at t+1 at the earliest.
  - out_msg is driven from the head entry registers.
- Dequeue: on out_en & ~out_reject, the head entry is invalidated and head advances by 1.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Order: issue is strictly in order. A ready younger entry never bypasses a stalled head.
- Empty queue: out_en=0; out_msg is don't-care.

Optional Feature:
FPU_ISSUE_QUEUE_WAKEUP_BYPASS_EN
- With the macro defined:
  - When the head's only missing source(s) match wb_phys with wb_en=1, out_en is asserted in that same cycle.
  - out_msg carries wb_data in the affected source field(s).
  - The register update still happens, so out_msg stays stable if the transfer is rejected.
  - Head-to-FPU latency after wakeup becomes 0 cycles.
- Without the macro: registered-only readiness and 1-cycle latency, as in Behaviour.

Test Plan:
1. Reset, then enqueue funct5=0 (fadd) with both sources ready, data 0x3F800000 and 0x40000000, out_reject=0 -> out_en=1 the next cycle with out_msg matching, entry dequeued, count returns to 0.
2. Enqueue an entry with src1 not ready, tag 12. Drive wb_en=1, wb_phys=12, wb_data=0x40400000 at cycle t -> out_en=0 at t, out_en=1 at t+1 with src1.data=0x40400000. With bypass macro defined: out_en=1 at t.
3. Fill 4 entries with out_reject held 1 -> in_reject=1 on the 5th offer. Hold out_reject=1 for 3 cycles -> out_msg bit-stable. Release -> entries issue in commit_id order 0,1,2,3.
4. Offer an enqueue with src2 tag 7 not ready while wb_phys=7 and wb_en=1 in the same cycle -> stored entry ready; issues the next cycle.
5. 3 entries queued, head waiting on tag 9; assert flash -> that cycle in_reject=1 and out_en=0; next cycle count=0. A later wb_phys=9 produces no issue.
6. Head not ready, second entry ready -> out_en stays 0, confirming no out-of-order issue. Waking the head -> head issues first, then the second entry on the next accepted cycle.

Source files
------------

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: in-order issue queue between dispatch and the FPU interconnect.
// Buffers up to DEPTH instructions and snoops the writeback bus so that pending
// source operands are captured. Only the head entry is ever offered.
//
// Message layout (MSB first), shared by in_msg and out_msg:
//   funct5[5] | dest_phys[PHYS_W] | dest_logic[5] | commit_id[CID_W] |
//   src1 {ready, tag[PHYS_W], data[32]} | src2 {ready, tag[PHYS_W], data[32]}
//
// Optional feature macro: FPU_ISSUE_QUEUE_WAKEUP_BYPASS_EN
//   When defined, a writeback that supplies the head's last missing source(s)
//   makes the head issuable in that same cycle, with wb_data forwarded into
//   out_msg. Without it, readiness comes from registered flags only.
module fpu_issue_queue #(
   parameter int DEPTH  = 4,
   parameter int PHYS_W = 6,
   parameter int CID_W  = 4,
   localparam int LOGIC_W = 5,
   localparam int MSG_W   = 5 + PHYS_W + LOGIC_W + CID_W + 2 * (1 + PHYS_W + 32)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flash,
   input  logic              in_en,
   input  logic [MSG_W-1:0]  in_msg,
   output logic              in_reject,
   input  logic              wb_en,
   input  logic [PHYS_W-1:0] wb_phys,
   input  logic [31:0]       wb_data,
   output logic              out_en,
   output logic [MSG_W-1:0]  out_msg,
   input  logic              out_reject
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int SRC_W  = 1 + PHYS_W + 32;
   localparam int META_W = 5 + PHYS_W + LOGIC_W + CID_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Entry storage: non-operand fields kept together, operands split out so
   // that the wakeup logic can update them per source.
   logic [META_W-1:0] r_meta [DEPTH];
   logic [PHYS_W-1:0] r_tag1 [DEPTH];
   logic [PHYS_W-1:0] r_tag2 [DEPTH];
   logic [31:0]       r_dat1 [DEPTH];
   logic [31:0]       r_dat2 [DEPTH];
   logic [DEPTH-1:0]  r_rdy1;
   logic [DEPTH-1:0]  r_rdy2;
   logic [DEPTH-1:0]  r_valid;

   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;

   logic              w_clr;
   logic              w_push;
   logic              w_pop;

   logic [SRC_W-1:0]  w_in_s1;
   logic [SRC_W-1:0]  w_in_s2;
   logic              w_in_wk1;
   logic              w_in_wk2;

   logic              w_h_byp1;
   logic              w_h_byp2;
   logic              w_h_rdy1;
   logic              w_h_rdy2;
   logic [31:0]       w_h_dat1;
   logic [31:0]       w_h_dat2;

   assign w_clr = reset | flash;

   // Incoming sources; a broadcast in the enqueue cycle must not be lost.
   assign w_in_s1  = in_msg[2*SRC_W-1 -: SRC_W];
   assign w_in_s2  = in_msg[SRC_W-1:0];
   assign w_in_wk1 = wb_en & ~w_in_s1[SRC_W-1] & (w_in_s1[32 +: PHYS_W] == wb_phys);
   assign w_in_wk2 = wb_en & ~w_in_s2[SRC_W-1] & (w_in_s2[32 +: PHYS_W] == wb_phys);

`ifdef FPU_ISSUE_QUEUE_WAKEUP_BYPASS_EN
   assign w_h_byp1 = wb_en & ~r_rdy1[r_head] & (r_tag1[r_head] == wb_phys);
   assign w_h_byp2 = wb_en & ~r_rdy2[r_head] & (r_tag2[r_head] == wb_phys);
`else
   assign w_h_byp1 = 1'b0;
   assign w_h_byp2 = 1'b0;
`endif

   assign w_h_rdy1 = r_rdy1[r_head] | w_h_byp1;
   assign w_h_rdy2 = r_rdy2[r_head] | w_h_byp2;
   assign w_h_dat1 = w_h_byp1 ? wb_data : r_dat1[r_head];
   assign w_h_dat2 = w_h_byp2 ? wb_data : r_dat2[r_head];

   // Full blocks enqueue even if the head leaves this cycle (no pass-through).
   assign in_reject = w_clr | (r_count == FULL_CNT);
   assign out_en    = ~w_clr & (r_count != '0) & w_h_rdy1 & w_h_rdy2;
   assign out_msg   = {r_meta[r_head],
                       w_h_rdy1, r_tag1[r_head], w_h_dat1,
                       w_h_rdy2, r_tag2[r_head], w_h_dat2};

   assign w_push = in_en & ~in_reject;
   assign w_pop  = out_en & ~out_reject;

   // Queue control: pointers, occupancy and entry valid bits.
   always_ff @(posedge clock) begin
      if (w_clr) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry payload: writeback snooping on resident entries, then enqueue write.
   // The tail slot is never valid when a push is accepted, so the two never
   // target the same live entry.
   always_ff @(posedge clock) begin
      if (wb_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_rdy1[i] && (r_tag1[i] == wb_phys)) begin
               r_rdy1[i] <= 1'b1;
               r_dat1[i] <= wb_data;
            end
            if (r_valid[i] && !r_rdy2[i] && (r_tag2[i] == wb_phys)) begin
               r_rdy2[i] <= 1'b1;
               r_dat2[i] <= wb_data;
            end
         end
      end
      if (w_push) begin
         r_meta[r_tail] <= in_msg[MSG_W-1 -: META_W];
         r_rdy1[r_tail] <= w_in_s1[SRC_W-1] | w_in_wk1;
         r_tag1[r_tail] <= w_in_s1[32 +: PHYS_W];
         r_dat1[r_tail] <= w_in_wk1 ? wb_data : w_in_s1[31:0];
         r_rdy2[r_tail] <= w_in_s2[SRC_W-1] | w_in_wk2;
         r_tag2[r_tail] <= w_in_s2[32 +: PHYS_W];
         r_dat2[r_tail] <= w_in_wk2 ? wb_data : w_in_s2[31:0];
      end
   end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Testbench for fpu_issue_queue: directed scenarios checked every cycle against
// a queue-based behavioural model, plus literal expectations per scenario.
module tb_fpu_issue_queue;

   typedef struct packed {
      logic [4:0]  f5;
      logic [5:0]  dp;
      logic [4:0]  dl;
      logic [3:0]  cid;
      logic        r1;
      logic [5:0]  t1;
      logic [31:0] d1;
      logic        r2;
      logic [5:0]  t2;
      logic [31:0] d2;
   } ent_t;

   logic        clock;
   logic        reset;
   logic        flash;
   logic        in_en;
   logic [97:0] in_msg;
   logic        in_reject;
   logic        wb_en;
   logic [5:0]  wb_phys;
   logic [31:0] wb_data;
   logic        out_en;
   logic [97:0] out_msg;
   logic        out_reject;

   fpu_issue_queue dut (
      .clock      (clock),
      .reset      (reset),
      .flash      (flash),
      .in_en      (in_en),
      .in_msg     (in_msg),
      .in_reject  (in_reject),
      .wb_en      (wb_en),
      .wb_phys    (wb_phys),
      .wb_data    (wb_data),
      .out_en     (out_en),
      .out_msg    (out_msg),
      .out_reject (out_reject)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   ent_t        mq[$];
   int          issued[$];
   logic        last_in_reject;
   logic        last_out_en;
   logic [97:0] last_out_msg;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic ent_t mk(input int cid, input bit r1, input int t1, input logic [31:0] d1,
                               input bit r2, input int t2, input logic [31:0] d2);
      ent_t e;
      e.f5  = 5'(cid + 1);
      e.dp  = 6'(cid + 32);
      e.dl  = 5'(cid + 3);
      e.cid = 4'(cid);
      e.r1  = r1;
      e.t1  = 6'(t1);
      e.d1  = r1 ? d1 : 32'h0;
      e.r2  = r2;
      e.t2  = 6'(t2);
      e.d2  = r2 ? d2 : 32'h0;
      return e;
   endfunction

   // Model: what the queue must present given its contents and current inputs.
   task automatic model_outputs(output logic rej, output logic en, output logic [97:0] msg);
      ent_t h;
      logic clr;
      clr = reset | flash;
      rej = clr | (mq.size() == 4);
      en  = 1'b0;
      msg = '0;
      if (!clr && mq.size() != 0) begin
         h = mq[0];
`ifdef FPU_ISSUE_QUEUE_WAKEUP_BYPASS_EN
         if (wb_en && !h.r1 && h.t1 == wb_phys) begin h.r1 = 1'b1; h.d1 = wb_data; end
         if (wb_en && !h.r2 && h.t2 == wb_phys) begin h.r2 = 1'b1; h.d2 = wb_data; end
`endif
         en  = h.r1 & h.r2;
         msg = h;
      end
   endtask

   // Model: state change at the clock edge.
   task automatic model_update(input logic rej, input logic en);
      ent_t e;
      if (reset || flash) begin
         mq.delete();
      end else begin
         if (en && !out_reject) void'(mq.pop_front());
         if (in_en && !rej) mq.push_back(ent_t'(in_msg));
         if (wb_en) begin
            for (int k = 0; k < mq.size(); k++) begin
               e = mq[k];
               if (!e.r1 && e.t1 == wb_phys) begin e.r1 = 1'b1; e.d1 = wb_data; end
               if (!e.r2 && e.t2 == wb_phys) begin e.r2 = 1'b1; e.d2 = wb_data; end
               mq[k] = e;
            end
         end
      end
   endtask

   // One clock: compare on the falling edge, advance the model on the rising edge.
   task automatic cycle();
      logic        exp_rej;
      logic        exp_en;
      logic [97:0] exp_msg;
      ent_t        o;
      @(negedge clock);
      model_outputs(exp_rej, exp_en, exp_msg);
      chk("in_reject", 128'(in_reject), 128'(exp_rej));
      chk("out_en", 128'(out_en), 128'(exp_en));
      if (exp_en) chk("out_msg", 128'(out_msg), 128'(exp_msg));
      last_in_reject = in_reject;
      last_out_en    = out_en;
      last_out_msg   = out_msg;
      if (out_en && !out_reject) begin
         o = ent_t'(out_msg);
         issued.push_back(int'(o.cid));
      end
      @(posedge clock);
      model_update(exp_rej, exp_en);
      #1;
   endtask

   initial begin
      ent_t e;
      ent_t cap;
      clock = 0; reset = 1; flash = 0; in_en = 0; in_msg = '0;
      wb_en = 0; wb_phys = '0; wb_data = '0; out_reject = 0;

      // Reset state
      cycle();
      chk("rst_in_reject", 128'(last_in_reject), 128'(1'b1));
      chk("rst_out_en", 128'(last_out_en), 128'(1'b0));
      cycle();
      reset = 0;
      cycle();
      chk("idle_in_reject", 128'(last_in_reject), 128'(1'b0));

      // 1: fadd with both sources ready issues the next cycle
      e = mk(0, 1, 1, 32'h3F800000, 1, 2, 32'h40000000);
      e.f5 = 5'd0;
      in_msg = e; in_en = 1;
      cycle();
      in_en = 0;
      cycle();
      chk("t1_out_en", 128'(last_out_en), 128'(1'b1));
      chk("t1_out_msg", 128'(last_out_msg), 128'(e));
      cycle();
      chk("t1_empty_en", 128'(last_out_en), 128'(1'b0));
      chk("t1_empty_rej", 128'(last_in_reject), 128'(1'b0));

      // 2: wakeup of src1 tag 12
      in_msg = mk(1, 0, 12, 0, 1, 3, 32'h00000001); in_en = 1;
      cycle();
      in_en = 0; wb_en = 1; wb_phys = 6'd12; wb_data = 32'h40400000;
      cycle();
`ifdef FPU_ISSUE_QUEUE_WAKEUP_BYPASS_EN
      chk("t2_wake_cycle_en", 128'(last_out_en), 128'(1'b1));
      e = ent_t'(last_out_msg);
      chk("t2_bypass_d1", 128'(e.d1), 128'(32'h40400000));
      wb_en = 0;
      cycle();
      chk("t2_after_en", 128'(last_out_en), 128'(1'b0));
`else
      chk("t2_wake_cycle_en", 128'(last_out_en), 128'(1'b0));
      wb_en = 0;
      cycle();
      chk("t2_after_en", 128'(last_out_en), 128'(1'b1));
      e = ent_t'(last_out_msg);
      chk("t2_d1", 128'(e.d1), 128'(32'h40400000));
`endif
      cycle();

      // 3: fill under backpressure, hold stable, drain in order
      out_reject = 1;
      for (int i = 0; i < 4; i++) begin
         in_msg = mk(i, 1, 10 + i, 32'h1000 + i, 1, 20 + i, 32'h2000 + i); in_en = 1;
         cycle();
      end
      in_msg = mk(7, 1, 1, 32'h7, 1, 1, 32'h7);
      cycle();
      chk("t3_full_reject", 128'(last_in_reject), 128'(1'b1));
      cap = ent_t'(last_out_msg);
      chk("t3_head_cid", 128'(cap.cid), 128'(4'd0));
      in_en = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t3_stable_msg", 128'(last_out_msg), 128'(cap));
      end
      out_reject = 0;
      issued.delete();
      for (int i = 0; i < 5; i++) cycle();
      chk("t3_issue_count", 128'(issued.size()), 128'(4));
      for (int i = 0; i < 4; i++)
         chk("t3_order", 128'(issued.size() > i ? issued[i] : -1), 128'(i));

      // 4: wakeup in the enqueue cycle is not lost
      in_msg = mk(5, 1, 4, 32'h5, 0, 7, 0); in_en = 1;
      wb_en = 1; wb_phys = 6'd7; wb_data = 32'hABCD0000;
      cycle();
      in_en = 0; wb_en = 0;
      cycle();
      chk("t4_out_en", 128'(last_out_en), 128'(1'b1));
      e = ent_t'(last_out_msg);
      chk("t4_d2", 128'(e.d2), 128'(32'hABCD0000));
      cycle();

      // 5: flash discards queued entries
      in_msg = mk(6, 0, 9, 0, 1, 1, 32'h6); in_en = 1;
      cycle();
      in_msg = mk(7, 1, 1, 32'h7, 1, 2, 32'h7);
      cycle();
      in_msg = mk(8, 1, 1, 32'h8, 1, 2, 32'h8);
      cycle();
      flash = 1;
      cycle();
      chk("t5_flash_rej", 128'(last_in_reject), 128'(1'b1));
      chk("t5_flash_en", 128'(last_out_en), 128'(1'b0));
      flash = 0; in_en = 0;
      cycle();
      chk("t5_after_rej", 128'(last_in_reject), 128'(1'b0));
      wb_en = 1; wb_phys = 6'd9; wb_data = 32'h9;
      cycle();
      wb_en = 0;
      cycle();
      chk("t5_no_issue", 128'(last_out_en), 128'(1'b0));

      // 6: stalled head blocks a ready younger entry
      in_msg = mk(8, 0, 20, 0, 1, 1, 32'h8); in_en = 1;
      cycle();
      in_msg = mk(9, 1, 2, 32'h9, 1, 3, 32'h9);
      cycle();
      in_en = 0;
      issued.delete();
      cycle();
      cycle();
      chk("t6_blocked_en", 128'(last_out_en), 128'(1'b0));
      wb_en = 1; wb_phys = 6'd20; wb_data = 32'h5;
      cycle();
      wb_en = 0;
      for (int i = 0; i < 3; i++) cycle();
      chk("t6_issue_count", 128'(issued.size()), 128'(2));
      chk("t6_first", 128'(issued.size() > 0 ? issued[0] : -1), 128'(8));
      chk("t6_second", 128'(issued.size() > 1 ? issued[1] : -1), 128'(9));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
